// File: rtl/iwdg_pkg.sv
// iwdg_pkg: IWDG key values, register offsets, field widths and kicker FSM states
package iwdg_pkg;
  localparam logic [15:0] KEY_ACCESS = 16'h5555;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [15:0] KEY_COUNT = 16'hCCCC;
  localparam logic [31:0] OFS_KR = 32'h0;
  localparam logic [31:0] OFS_PR = 32'h4;
  localparam logic [31:0] OFS_RLR = 32'h8;
  localparam logic [31:0] OFS_ST = 32'hC;
  localparam int PR_W = 3;
  localparam int RLR_W = 12;
  typedef enum logic [3:0] {
    S_IDLE, S_UNLOCK, S_WR_PR, S_WR_RLR, S_POLL, S_RELOAD, S_COUNT, S_WAIT, S_KICK, S_ERR
  } state_t;
endpackage

// File: rtl/wb_single_access.sv
// wb_single_access: one registered Wishbone access per request, aborted after ACK_TIMEOUT cycles
module wb_single_access #(
  parameter int AW = 32,
  parameter int DW = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_dat,
  input  logic          ack,
  input  logic [DW-1:0] rd_dat,
  output logic          cyc,
  output logic          stb,
  output logic          we,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] dat,
  output logic          done,
  output logic          timeout,
  output logic [DW-1:0] rdata
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= 1'b0;
      stb <= 1'b0;
      we <= 1'b0;
      adr <= '0;
      dat <= '0;
      cnt <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      timeout <= 1'b0;
      if (cyc) begin
        // bus returns to all-zero on completion so an aborted access leaves nothing driven
        if (ack || cnt == TW'(ACK_TIMEOUT - 1)) begin
          cyc <= 1'b0;
          stb <= 1'b0;
          we <= 1'b0;
          adr <= '0;
          dat <= '0;
          done <= ack;
          timeout <= !ack;
          if (ack) rdata <= rd_dat;
        end
        cnt <= cnt + TW'(1);
      end else if (req) begin
        cyc <= 1'b1;
        stb <= 1'b1;
        we <= req_we;
        adr <= req_adr;
        dat <= req_dat;
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/iwdg_wb_kicker.sv
// iwdg_wb_kicker: configures the IWDG over Wishbone and refreshes it while healthy.
// IWDG_KICKER_ST_POLL_EN adds polling of ST after the RLR write.
module iwdg_wb_kicker
  import iwdg_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0100_0000,
  parameter int DAT_SIZE = 16,
  parameter int IWDG_PR_SIZE = 3,
  parameter int IWDG_RLR_SIZE = 12,
  parameter int KICK_PERIOD = 64,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
  input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
  input  logic                     healthy,
  output logic                     cyc_m2s,
  output logic                     stb_m2s,
  output logic                     we_m2s,
  output logic [31:0]              adr_m2s,
  output logic [DAT_SIZE-1:0]      dat_m2s,
  input  logic [DAT_SIZE-1:0]      dat_s2m,
  input  logic                     ack_s2m,
  output logic                     running,
  output logic                     bus_err,
  output logic [15:0]              kick_cnt
);
  localparam int PW = $clog2(KICK_PERIOD);
`ifdef IWDG_KICKER_ST_POLL_EN
  localparam state_t RLR_NEXT = S_POLL;
`else
  localparam state_t RLR_NEXT = S_RELOAD;
`endif
  state_t state;
  logic [PW-1:0] pcnt;
  logic [IWDG_PR_SIZE-1:0] pr_q;
  logic [IWDG_RLR_SIZE-1:0] rlr_q;
  logic req, req_we, done, timeout, st_busy;
  logic [31:0] req_adr;
  logic [DAT_SIZE-1:0] req_dat, rdata;
  // a busy ST read relaunches on its done cycle, leaving exactly one idle cycle between reads
  always_comb begin
    st_busy = |(rdata & DAT_SIZE'(3));
    req = (state inside {S_UNLOCK, S_WR_PR, S_WR_RLR, S_POLL, S_RELOAD, S_COUNT, S_KICK}) &&
          !cyc_m2s && !timeout && (!done || (state == S_POLL && st_busy));
    req_we = state != S_POLL;
    req_adr = BASE_ADR + (state == S_WR_PR ? OFS_PR : state == S_WR_RLR ? OFS_RLR :
                          state == S_POLL ? OFS_ST : OFS_KR);
    req_dat = state == S_UNLOCK ? DAT_SIZE'(KEY_ACCESS) : state == S_WR_PR ? DAT_SIZE'(pr_q) :
              state == S_WR_RLR ? DAT_SIZE'(rlr_q) : state == S_COUNT ? DAT_SIZE'(KEY_COUNT) :
              state == S_POLL ? '0 : DAT_SIZE'(KEY_RELOAD);
  end
  wb_single_access #(.AW(32), .DW(DAT_SIZE), .ACK_TIMEOUT(ACK_TIMEOUT)) u_acc (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat),
    .ack(ack_s2m), .rd_dat(dat_s2m), .cyc(cyc_m2s), .stb(stb_m2s), .we(we_m2s), .adr(adr_m2s),
    .dat(dat_m2s), .done(done), .timeout(timeout), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pcnt <= '0;
      pr_q <= '0;
      rlr_q <= '0;
      running <= 1'b0;
      bus_err <= 1'b0;
      kick_cnt <= '0;
    end else if (timeout) begin
      state <= S_ERR;
      bus_err <= 1'b1;
      running <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR: if (start) begin
          state <= S_UNLOCK;
          bus_err <= 1'b0;
          pr_q <= cfg_pr;
          rlr_q <= cfg_rlr;
        end
        S_UNLOCK: if (done) state <= S_WR_PR;
        S_WR_PR: if (done) state <= S_WR_RLR;
        S_WR_RLR: if (done) state <= RLR_NEXT;
        S_POLL: if (done && !st_busy) state <= S_RELOAD;
        S_RELOAD: if (done) state <= S_COUNT;
        S_COUNT: if (done) begin
          state <= S_WAIT;
          running <= 1'b1;
          pcnt <= PW'(KICK_PERIOD - 1);
        end
        S_WAIT: if (pcnt != '0) pcnt <= pcnt - PW'(1);
                else if (healthy) state <= S_KICK;
                else pcnt <= PW'(KICK_PERIOD - 1);
        S_KICK: if (done) begin
          state <= S_WAIT;
          kick_cnt <= kick_cnt + 16'd1;
          pcnt <= PW'(KICK_PERIOD - 1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/iwdg_wb_kicker.md
Name: iwdg_wb_kicker

Overview:
- Wishbone master that sits directly upstream of the independent watchdog and drives its slave port.
- On `start` it runs the configuration sequence: unlock (`h5555`), prescaler, reload value, reload (`hAAAA`), count start (`hCCCC`).
- It then refreshes the watchdog periodically with `hAAAA` while the system-health input `healthy` is high.
- When `healthy` drops, kicks stop so the watchdog can fire `iwdg_rst`.

Parameters:
- BASE_ADR, 32'h0100_0000, watchdog base address; KR = +0x0, PR = +0x4, RLR = +0x8, ST = +0xC.
- DAT_SIZE, 16, Wishbone data width.
- IWDG_PR_SIZE, 3, prescaler field width.
- IWDG_RLR_SIZE, 12, reload field width.
- KICK_PERIOD, 64, clk cycles between refresh writes (>= 4).
- ACK_TIMEOUT, 16, max clk cycles waiting for `ack_s2m` per access (>= 2).

Ports:
- clk  in  1  system/bus clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches the configuration sequence from IDLE or ERR.
- cfg_pr  in  3  prescaler code written to PR.
- cfg_rlr  in  12  reload value written to RLR.
- healthy  in  1  1 = kick allowed.
- cyc_m2s  out  1  Wishbone cycle.
- stb_m2s  out  1  Wishbone strobe.
- we_m2s  out  1  Wishbone write enable.
- adr_m2s  out  32  Wishbone address.
- dat_m2s  out  16  Wishbone write data; PR/RLR values are zero-extended.
- dat_s2m  in  16  Wishbone read data.
- ack_s2m  in  1  Wishbone acknowledge.
- running  out  1  countdown started and kicking active.
- bus_err  out  1  sticky ack-timeout flag.
- kick_cnt  out  16  number of completed kicks, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (sync, active-high, priority over everything):
  - All outputs 0; FSM in IDLE; period and timeout counters cleared.
  - Reset mid-access drops `cyc_m2s` and `stb_m2s` on the same edge; the watchdog slave tolerates an aborted cycle.
- Access rules, all outputs registered:
  - One access = set `cyc_m2s`/`stb_m2s`/`we_m2s`/`adr_m2s`/`dat_m2s` on one edge, hold them stable until `ack_s2m` is sampled 1.
  - On that same edge, `cyc_m2s` and `stb_m2s` go 0.
  - At least one idle cycle follows every access, so `cyc_m2s` is never high on two back-to-back accesses.
  - Minimum access latency is 2 clk cycles.
  - An `ack_s2m` seen while `cyc_m2s` = 0 is ignored.
- Timeout:
  - A counter counts cycles with `cyc_m2s` = 1.
  - When it reaches ACK_TIMEOUT without ack: drop `cyc_m2s`/`stb_m2s`, set `bus_err` = 1, clear `running`, go to ERR.
- FSM: IDLE -> UNLOCK -> WR_PR -> WR_RLR -> [POLL] -> RELOAD -> COUNT -> WAIT <-> KICK; any -> ERR.
  - IDLE: wait for `start`.
  - UNLOCK: write `h5555` to KR.
  - WR_PR: write `cfg_pr` to PR.
  - WR_RLR: write `cfg_rlr` to RLR.
  - RELOAD: write `hAAAA` to KR.
  - COUNT: write `hCCCC` to KR; on its ack, set `running` = 1 and load the period counter with KICK_PERIOD-1.
  - WAIT: decrement the period counter.
    - At 0 with `healthy` = 1: go to KICK.
    - At 0 with `healthy` = 0: reload the counter, stay in WAIT, no bus access.
  - KICK: write `hAAAA` to KR; on ack, increment `kick_cnt`, reload the counter, return to WAIT.
  - ERR: hold all bus outputs 0.
    - `start` clears `bus_err` and restarts at UNLOCK; `kick_cnt` is kept.
- `cfg_pr` and `cfg_rlr` are sampled when `start` is accepted; later changes are ignored until the next `start`.
- `start` outside IDLE/ERR is ignored.
- `healthy` is sampled only on the cycle the counter hits 0.
- `dat_s2m` is used only by POLL.

Optional Feature:
- Macro: IWDG_KICKER_ST_POLL_EN.
- Defined: POLL state after WR_RLR.
  - Read ST at BASE_ADR+0xC, repeating with one idle cycle between reads, until `dat_s2m[1:0]` = 0 (PR/RLR update complete); then go to RELOAD.
  - Each read is subject to ACK_TIMEOUT.
  - No overall poll limit.
- Undefined: POLL state absent; WR_RLR goes directly to RELOAD.

Decomposition:
- Package iwdg_pkg holds:
  - Key constants KEY_ACCESS = 16'h5555, KEY_RELOAD = 16'hAAAA, KEY_COUNT = 16'hCCCC.
  - Register offsets KR/PR/RLR/ST.
  - Field widths.
  - FSM state enum.
- One natural sub-module, wb_single_access:
  - Takes a request pulse with we/adr/dat.
  - Runs one Wishbone access with ACK_TIMEOUT.
  - Returns done, timeout and rdata.
  - The FSM sequences requests through it.

Test Plan:
- Reset then `start` with cfg_pr = 3'b001, cfg_rlr = 12'h001, slave acks after 1 cycle -> KR/5555, PR/0001, RLR/0001, KR/AAAA, KR/CCCC writes in order at 0x0100_0000/04/08/00/00; then `running` = 1.
- `healthy` = 1, KICK_PERIOD = 64 -> KR/AAAA writes every 64 + access cycles; `kick_cnt` increments 1, 2, 3.
- `healthy` = 0 for 200 cycles -> no bus activity; `kick_cnt` frozen; `healthy` back to 1 -> kick on the next counter expiry.
- Slave withholds ack on the PR write -> `cyc_m2s` drops after 16 cycles, `bus_err` = 1, `running` = 0; `start` -> `bus_err` clears and the sequence restarts at UNLOCK.
- `rst` asserted while `cyc_m2s` = 1 during a kick -> next edge all outputs 0, `kick_cnt` = 0.
- With IWDG_KICKER_ST_POLL_EN, ST returns 2'b01 twice then 0 -> three ST reads precede the KR/AAAA write; without the macro -> no ST reads.
